// File: rtl/progress_tx.sv
// -----------------------------------------------------------------------------
// progress_tx
//   Transmit side of the player-client progress link. Game logic queues
//   step requests; the block emits a 5-bit wrapping progress code one step
//   at a time and holds each code for HOLD cycles. The receiver rebuilds an
//   8-bit count by spotting the 31->0 wrap, so the code never skips a value.
//
// Parameters
//   HOLD      cycles each code value is held (1..255)
//   PEND_MAX  pending-queue ceiling (15..255)
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous reset, active-high despite the name
//   add        in   [3:0] steps requested (0..15)
//   add_valid  in   request strobe
//   add_ready  out  request can be accepted this cycle
//   clear      in   synchronous flush of queued work and current hold
//   out        out  [4:0] wrapping progress code (= sent[4:0])
//   sent       out  [7:0] total steps emitted, modulo 256
//   pending    out  [7:0] steps queued but not yet emitted
//   busy       out  work queued or a hold in progress
// -----------------------------------------------------------------------------
module progress_tx #(
  parameter int HOLD     = 4,
  parameter int PEND_MAX = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] add,
  input  logic       add_valid,
  output logic       add_ready,
  input  logic       clear,
  output logic [4:0] out,
  output logic [7:0] sent,
  output logic [7:0] pending,
  output logic       busy
);

  // A full 15-step request must always fit under the ceiling.
  localparam logic [7:0] READY_MAX = 8'(PEND_MAX - 15);
  localparam logic [7:0] HOLD_M1   = 8'(HOLD - 1);

  // The engine state is fully carried by the hold timer: a non-zero timer
  // means a code is still being held.
  typedef enum logic {
    S_READY = 1'b0,
    S_WAIT  = 1'b1
  } state_e;

  logic [7:0] sent_q,    sent_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] timer_q,   timer_d;
  logic [8:0] pend_sum;
  logic       accept;
  logic       step;
  state_e     state;

  assign state     = (timer_q != 8'd0) ? S_WAIT : S_READY;
  assign add_ready = !clear && (pending_q <= READY_MAX);
  assign accept    = add_valid && add_ready;

  assign out     = sent_q[4:0];
  assign sent    = sent_q;
  assign pending = pending_q;
  assign busy    = (pending_q != 8'd0) || (timer_q != 8'd0);

  always_comb begin
    sent_d    = sent_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    step      = 1'b0;
    pend_sum  = '0;
    if (clear) begin
      // Flush overrides both stepping and accepting; sent/out are kept so
      // the receiver's reconstructed count stays consistent.
      pending_d = 8'd0;
      timer_d   = 8'd0;
    end else begin
      case (state)
        S_WAIT: timer_d = timer_q - 8'd1;
        S_READY: begin
          if (pending_q != 8'd0) begin
            step    = 1'b1;
            sent_d  = sent_q + 8'd1;  // 255 -> 0 wrap is intended
            timer_d = HOLD_M1;        // HOLD=1 reloads 0: step every cycle
          end
        end
        default: timer_d = 8'd0;
      endcase
      // Add and step can land in the same cycle; 9 bits keep the
      // intermediate exact, and add_ready bounds the result to PEND_MAX.
      pend_sum  = {1'b0, pending_q}
                + {5'd0, (accept ? add : 4'd0)}
                - {8'd0, step};
      pending_d = pend_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sent_q    <= 8'd0;
      pending_q <= 8'd0;
      timer_q   <= 8'd0;
    end else begin
      sent_q    <= sent_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
    end
  end

endmodule
